ysyx_exu_csr_seq: RTL

- Initiator side of the execute-stage CSR interface: accepts one CSR/system micro-op at a time from issue and sequences it into the CSR register file.
- The sequence is a read phase, a single-cycle commit strobe, then a writeback/redirect response.
- Handles CSRRW/S/C and their immediate forms, ECALL, EBREAK, MRET and upstream traps.
- Sits between issue and the CSR file; its response feeds writeback and the frontend redirect.

---
 rtl/ysyx_exu_csr_seq.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ysyx_exu_csr_seq.sv
// ysyx_exu_csr_seq: sequences one CSR/system micro-op through read, commit strobe and writeback/redirect response.
// Optional read-only CSR write trap enabled by defining YSYX_CSR_SEQ_ACCESS_CHECK_EN.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif
module ysyx_exu_csr_seq #(
  parameter int XLEN = `YSYX_XLEN,
  parameter int R_W = 12,
  parameter int REG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [2:0]       in_funct3,
  input  logic [R_W-1:0]   in_csr_addr,
  input  logic [REG_W-1:0] in_rs1_idx,
  input  logic [XLEN-1:0]  in_rs1_val,
  input  logic [REG_W-1:0] in_rd,
  input  logic             in_ecall,
  input  logic             in_ebreak,
  input  logic             in_mret,
  input  logic             in_trap,
  input  logic [XLEN-1:0]  in_cause,
  input  logic [XLEN-1:0]  in_tval,
  input  logic             flush,
  output logic             csr_valid,
  output logic             csr_wen,
  output logic [R_W-1:0]   csr_waddr,
  output logic [R_W-1:0]   csr_raddr,
  output logic [XLEN-1:0]  csr_wdata,
  output logic [XLEN-1:0]  csr_pc,
  output logic             csr_ecall,
  output logic             csr_ebreak,
  output logic             csr_mret,
  output logic             csr_trap,
  output logic [XLEN-1:0]  csr_cause,
  output logic [XLEN-1:0]  csr_tval,
  input  logic [XLEN-1:0]  csr_rdata,
  input  logic [XLEN-1:0]  csr_mtvec,
  input  logic [XLEN-1:0]  csr_mepc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [REG_W-1:0] out_rd,
  output logic             out_rd_wen,
  output logic [XLEN-1:0]  out_rd_data,
  output logic             out_redirect,
  output logic [XLEN-1:0]  out_npc
);
  typedef enum logic [1:0] {IDLE, READ, COMMIT, RESP} state_t;
  state_t r_state, w_next;
  logic [XLEN-1:0] r_pc, r_rs1_val, r_cause, r_tval, r_old, r_npc;
  logic [2:0] r_funct3;
  logic [R_W-1:0] r_addr;
  logic [REG_W-1:0] r_rs1_idx, r_rd;
  logic r_ecall, r_ebreak, r_mret, r_trap, r_redirect, r_rd_wen;
  logic w_accept, w_commit, w_sys, w_csr, w_wen, w_fault;
  logic w_trap, w_ecall, w_ebreak, w_mret;
  logic [XLEN-1:0] w_src;
  assign w_accept = in_valid && in_ready && !flush;
  assign w_commit = r_state == COMMIT;
  // Fixed priority: trap > ecall > ebreak > mret > CSR op
  assign w_trap   = r_trap;
  assign w_ecall  = !r_trap && r_ecall;
  assign w_ebreak = !r_trap && !r_ecall && r_ebreak;
  assign w_mret   = !r_trap && !r_ecall && !r_ebreak && r_mret;
  assign w_sys    = r_trap || r_ecall || r_ebreak || r_mret;
  assign w_csr    = !w_sys && r_funct3[1:0] != 2'b00;
  assign w_wen    = w_csr && (r_funct3[1:0] == 2'b01 || r_rs1_idx != '0);
  assign w_src    = r_funct3[2] ? {{(XLEN-REG_W){1'b0}}, r_rs1_idx} : r_rs1_val;
`ifdef YSYX_CSR_SEQ_ACCESS_CHECK_EN
  assign w_fault  = w_wen && r_addr[R_W-1:R_W-2] == 2'b11;
`else
  assign w_fault  = 1'b0;
`endif
  assign in_ready     = r_state == IDLE;
  assign csr_valid    = w_commit && (w_sys || w_csr);
  assign csr_wen      = w_commit && w_wen && !w_fault;
  assign csr_ecall    = w_commit && w_ecall;
  assign csr_ebreak   = w_commit && w_ebreak;
  assign csr_mret     = w_commit && w_mret;
  assign csr_trap     = w_commit && (w_trap || w_fault);
  assign csr_cause    = !csr_trap ? '0 : w_fault ? XLEN'(2) : r_cause;
  assign csr_tval     = csr_trap && !w_fault ? r_tval : '0;
  assign csr_raddr    = r_addr;
  assign csr_waddr    = r_addr;
  assign csr_pc       = r_pc;
  assign csr_wdata    = r_funct3[1:0] == 2'b01 ? w_src :
                        r_funct3[1:0] == 2'b10 ? (r_old | w_src) : (r_old & ~w_src);
  assign out_valid    = r_state == RESP;
  assign out_rd       = r_rd;
  assign out_rd_wen   = r_rd_wen;
  assign out_rd_data  = r_old;
  assign out_redirect = r_redirect;
  assign out_npc      = r_npc;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? READ : IDLE;
      READ:    w_next = flush ? IDLE : COMMIT;
      COMMIT:  w_next = RESP;
      RESP:    w_next = out_ready ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pc       <= '0;
      r_rs1_val  <= '0;
      r_cause    <= '0;
      r_tval     <= '0;
      r_old      <= '0;
      r_npc      <= '0;
      r_funct3   <= '0;
      r_addr     <= '0;
      r_rs1_idx  <= '0;
      r_rd       <= '0;
      r_ecall    <= 1'b0;
      r_ebreak   <= 1'b0;
      r_mret     <= 1'b0;
      r_trap     <= 1'b0;
      r_redirect <= 1'b0;
      r_rd_wen   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_pc      <= in_pc;
        r_funct3  <= in_funct3;
        r_addr    <= in_csr_addr;
        r_rs1_idx <= in_rs1_idx;
        r_rs1_val <= in_rs1_val;
        r_rd      <= in_rd;
        r_ecall   <= in_ecall;
        r_ebreak  <= in_ebreak;
        r_mret    <= in_mret;
        r_trap    <= in_trap;
        r_cause   <= in_cause;
        r_tval    <= in_tval;
      end
      if (r_state == READ) r_old <= csr_rdata;
      // mtvec/mepc sampled before the CSR file applies this commit
      if (w_commit) begin
        r_redirect <= w_sys || w_fault;
        r_npc      <= w_mret ? csr_mepc : (w_sys || w_fault) ? csr_mtvec : r_pc + XLEN'(4);
        r_rd_wen   <= w_csr && !w_fault && r_rd != '0;
      end
    end
  end
endmodule
